// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: sequential step, stall, trap/branch redirect
// and imem valid/ready handshake. Define PC_MISALIGN_CHECK_EN to align loaded targets.
module pc_gen #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int unsigned       PC_INC       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            redirect_taken,
    output logic            misalign_err
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            rt_q;

    logic            redir;
    logic [XLEN-1:0] target;
    logic            load;
    logic [XLEN-1:0] load_src;
    logic [XLEN-1:0] load_pc;
    logic            load_mis;

    assign redir  = trap_valid | redirect_valid;
    assign target = trap_valid ? trap_pc : redirect_pc;

`ifdef PC_MISALIGN_CHECK_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = (PC_INC == 2) ? XLEN'(1) : XLEN'(3);

    // Pending targets are stored raw and aligned at load time, so one check covers both paths.
    assign load_pc  = load_src & ~ALIGN_MASK;
    assign load_mis = |(load_src & ALIGN_MASK);
`else
    assign load_pc  = load_src;
    assign load_mis = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        load     = 1'b0;
        load_src = target;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redir) begin
                    // Flush overrides stall: en plays no part in a redirect.
                    if (fetch_ready) begin
                        load = 1'b1;
                    end else begin
                        pend_d  = target;
                        state_d = PEND;
                    end
                end else if (en && fetch_ready) begin
                    pc_d = pc_plus_inc;
                end
            end
            PEND: begin
                if (redir) pend_d = target;
                if (fetch_ready) begin
                    load     = 1'b1;
                    load_src = redir ? target : pend_q;
                    state_d  = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        if (load) pc_d = load_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            pend_q  <= '0;
            rt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            rt_q    <= load;
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    logic me_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) me_q <= 1'b0;
        else        me_q <= load & load_mis;
    end

    assign misalign_err = me_q;
`else
    logic unused_mis;
    assign unused_mis   = load_mis;
    assign misalign_err = 1'b0;
`endif

    assign fetch_valid    = (state_q != BOOT);
    assign pc_out         = pc_q;
    assign pc_plus_inc    = pc_q + INC;
    assign redirect_taken = rt_q;

endmodule
